// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_detector_pkg;

    localparam int unsigned DEF_CNT_W   = 8;
    localparam int unsigned MAX_PAT_W   = 32;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

    // Low-ones mask of len bits. The result is MAX_PAT_W wide and callers truncate it.
    function automatic logic [MAX_PAT_W-1:0] mask_of(input int unsigned len);
        logic [MAX_PAT_W-1:0] m;
        if (len >= MAX_PAT_W) begin
            m = '1;
        end else begin
            m = (MAX_PAT_W'(1) << len) - MAX_PAT_W'(1);
        end
        return m;
    endfunction

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear. When clear and increment coincide,
// the count is set to 1.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = inc_i ? CNT_W'(1) : '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector. It has a registered match flag,
// an overlapping or non-overlapping mode, and a saturating match counter.
module seq_detector_prog
    import seq_detector_pkg::*;
#(
    parameter int unsigned             MAX_LEN     = 6,
    parameter logic [MAX_LEN-1:0]      DEF_PATTERN = MAX_LEN'(6'b110110),
    parameter int unsigned             DEF_LEN     = 6,
    parameter int unsigned             CNT_W       = DEF_CNT_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in,
    input  logic                             in_valid,
    input  logic                             overlap,
    input  logic                             cfg_load,
    input  logic [MAX_LEN-1:0]               cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]     cfg_len,
    input  logic                             cnt_clr,
    output logic                             out,
    output logic [CNT_W-1:0]                 match_cnt
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               out_q, out_d;

    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] mask;
    logic               match;
    mode_e              mode;

    assign mode       = mode_e'(overlap);
    assign hist_shift = {hist_q[MAX_LEN-2:0], in};
    assign fill_inc   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    assign mask       = MAX_LEN'(mask_of(32'(len_q)));

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        out_d  = 1'b0;
        match  = 1'b0;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            // The match test uses the post-shift history and fill, so the flag
            // registers on the same edge that consumes the final pattern bit.
            match  = (len_q != '0) && (((hist_shift ^ pat_q) & mask) == '0)
                     && (fill_inc >= len_q);
            hist_d = hist_shift;
            fill_d = (match && (mode == MODE_NONOVL)) ? '0 : fill_inc;
            out_d  = match;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEF_PATTERN;
            len_q  <= LEN_W'(DEF_LEN);
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_match_cnt (
        .clk    (clk),
        .rst_ni (reset),
        .inc_i  (match),
        .clr_i  (cnt_clr),
        .cnt_o  (match_cnt)
    );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed and random bench for seq_detector_prog. It compares the DUT against a
// bit-queue reference model, using one instance with an 8-bit counter and one with a 2-bit counter.
module tb_seq_detector_prog;

    localparam int MAXL  = 6;
    localparam int LW    = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in = 1'b0;
    logic            in_valid = 1'b0;
    logic            overlap = 1'b0;
    logic            cfg_load = 1'b0;
    logic [MAXL-1:0] cfg_pattern = '0;
    logic [LW-1:0]   cfg_len = '0;
    logic            cnt_clr = 1'b0;
    logic            out_a, out_b;
    logic [7:0]      cnt_a;
    logic [1:0]      cnt_b;

    int ncomp = 0;
    int nfail = 0;

    // reference model state
    int          bits[$];
    int          fresh;
    logic [MAXL-1:0] pat_m;
    int          len_m;
    int          exp_out;
    int          exp_cnt_a;
    int          exp_cnt_b;

    always #5 clk = ~clk;

    seq_detector_prog u_dut (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cnt_clr(cnt_clr), .out(out_a), .match_cnt(cnt_a)
    );

    seq_detector_prog #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cnt_clr(cnt_clr), .out(out_b), .match_cnt(cnt_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        ncomp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        bits.delete();
        fresh     = 0;
        pat_m     = 6'b110110;
        len_m     = 6;
        exp_out   = 0;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
    endtask

    // The DUT sees a match when the newest len bits equal pat (bit 0 = newest)
    // and at least len bits have arrived since the last config, reset, or non-overlap hit.
    task automatic model_edge();
        int m;
        m = 0;
        if (cfg_load) begin
            pat_m = cfg_pattern;
            len_m = (int'(cfg_len) > MAXL) ? MAXL : int'(cfg_len);
            bits.delete();
            fresh = 0;
        end else if (in_valid) begin
            bits.push_back(int'(in));
            if (bits.size() > MAXL) void'(bits.pop_front());
            if (fresh < 1000) fresh++;
            if (len_m > 0 && fresh >= len_m) begin
                m = 1;
                for (int k = 0; k < len_m; k++)
                    if (bits[bits.size()-1-k] != int'(pat_m[k])) m = 0;
            end
            if (m == 1 && !overlap) fresh = 0;
        end
        exp_out = m;
        if (cnt_clr) begin
            exp_cnt_a = m;
            exp_cnt_b = m;
        end else if (m == 1) begin
            if (exp_cnt_a < 255) exp_cnt_a++;
            if (exp_cnt_b < 3) exp_cnt_b++;
        end
    endtask

    task automatic step(input logic b, input logic v, input string tag);
        in       = b;
        in_valid = v;
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ".out"},   int'(out_a), exp_out);
        check({tag, ".cnt8"},  int'(cnt_a), exp_cnt_a);
        check({tag, ".cnt2"},  int'(cnt_b), exp_cnt_b);
        in_valid = 1'b0;
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst.out", int'(out_a), 0);
        check("rst.cnt", int'(cnt_a), 0);
        #3;
        reset = 1'b1;
    endtask

    task automatic load_cfg(input logic [MAXL-1:0] p, input logic [LW-1:0] l, input logic b);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        step(b, 1'b1, "cfg");
    endtask

    logic [21:0] stream1;
    int          pulses;

    initial begin
        model_reset();
        #3;
        check("reset.out", int'(out_a), 0);
        check("reset.cnt8", int'(cnt_a), 0);
        check("reset.cnt2", int'(cnt_b), 0);
        reset = 1'b1;

        // Default 110110 stream: non-overlap should give 2 hits, and overlap should give 3.
        stream1 = 22'b0011011000110110110111;
        for (int mode = 0; mode < 2; mode++) begin
            do_reset();
            overlap = mode[0];
            pulses = 0;
            for (int i = 21; i >= 0; i--) begin
                step(stream1[i], 1'b1, mode ? "ovl" : "novl");
                pulses += int'(out_a);
            end
            check(mode ? "ovl.total" : "novl.total", int'(cnt_a), mode ? 3 : 2);
            check(mode ? "ovl.pulses" : "novl.pulses", pulses, mode ? 3 : 2);
        end

        // in_valid gaps between bits 3 and 4 should leave the single match intact.
        do_reset();
        overlap = 1'b0;
        step(1'b1, 1'b1, "gap"); step(1'b1, 1'b1, "gap"); step(1'b0, 1'b1, "gap");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "gap.idle");
        step(1'b1, 1'b1, "gap"); step(1'b1, 1'b1, "gap"); step(1'b0, 1'b1, "gap");
        check("gap.hit", int'(out_a), 1);

        // Pattern 1011 is loaded with a 1 presented alongside cfg_load, and that bit must be ignored.
        for (int mode = 1; mode >= 0; mode--) begin
            do_reset();
            overlap = mode[0];
            load_cfg(6'b001011, 3'd4, 1'b1);
            step(1'b1, 1'b1, "p4"); step(1'b0, 1'b1, "p4"); step(1'b1, 1'b1, "p4");
            step(1'b1, 1'b1, "p4");
            check("p4.first", int'(out_a), 1);
            step(1'b0, 1'b1, "p4"); step(1'b1, 1'b1, "p4"); step(1'b1, 1'b1, "p4");
            check("p4.second", int'(out_a), mode);
        end

        // Mid-stream asynchronous reset should not leave a partial match or a stale count.
        do_reset();
        overlap = 1'b1;
        step(1'b1, 1'b1, "mr"); step(1'b1, 1'b1, "mr"); step(1'b0, 1'b1, "mr");
        step(1'b1, 1'b1, "mr"); step(1'b1, 1'b1, "mr"); step(1'b0, 1'b1, "mr");
        step(1'b1, 1'b1, "mr"); step(1'b1, 1'b1, "mr"); step(1'b0, 1'b1, "mr");
        step(1'b1, 1'b1, "mr"); step(1'b1, 1'b1, "mr");
        check("mr.pre", int'(cnt_a), 2);
        do_reset();
        step(1'b0, 1'b1, "mr.post");
        check("mr.nopulse", int'(out_a), 0);

        // Randomized traffic also covers len 0 and out-of-range len values.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            overlap = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 3) begin
                cfg_load    = 1'b1;
                cfg_pattern = MAXL'($urandom);
                cfg_len     = LW'($urandom_range(0, 7));
            end
            cnt_clr = ($urandom_range(0, 99) < 2);
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 75), "rnd");
        end

        // With a len-1 pattern of 1, both counters saturate, and cnt_clr then behaves as specified.
        overlap = 1'b0;
        load_cfg(6'b000001, 3'd1, 1'b0);
        cnt_clr = 1'b1;
        step(1'b0, 1'b1, "sat.clr");
        for (int i = 0; i < 260; i++) step(1'b1, 1'b1, "sat");
        check("sat.cnt8", int'(cnt_a), 255);
        check("sat.cnt2", int'(cnt_b), 3);
        cnt_clr = 1'b1;
        step(1'b1, 1'b1, "sat.clrhit");
        check("clrhit.cnt2", int'(cnt_b), 1);
        cnt_clr = 1'b1;
        step(1'b0, 1'b1, "sat.clronly");
        check("clronly.cnt8", int'(cnt_a), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
